// File: rtl/sram_1r1w_resp_if.sv
// Request/response bundle between an algorithm core (master) and one
// physical 1R1W memory bank responder (slave).
interface sram_1r1w_resp_if #(
    parameter int WIDTH   = 32,
    parameter int BITVROW = 10,
    parameter int BITPADR = 14,
    parameter int BITPBNK = 4
);
    logic                         writeA;
    logic [BITVROW-1:0]           addrA;
    logic [WIDTH-1:0]             dinA;
    logic                         readB;
    logic [BITVROW-1:0]           addrB;
    logic                         inj_serr;
    logic                         inj_derr;
    logic                         vldB;
    logic [WIDTH-1:0]             doutB;
    logic                         fwrdB;
    logic                         serrB;
    logic                         derrB;
    logic [BITPADR-BITPBNK-1:0]   padrB;

    modport master (
        output writeA, addrA, dinA, readB, addrB, inj_serr, inj_derr,
        input  vldB, doutB, fwrdB, serrB, derrB, padrB
    );

    modport slave (
        input  writeA, addrA, dinA, readB, addrB, inj_serr, inj_derr,
        output vldB, doutB, fwrdB, serrB, derrB, padrB
    );
endinterface

// File: rtl/sram_1r1w_resp.sv
// Cycle-accurate responder for one 1R1W memory bank: flop-array storage,
// fixed read latency, same-cycle write-through forwarding, error injection
// on read data and physical-address return.
module sram_1r1w_resp #(
    parameter int WIDTH      = 32,
    parameter int NUMVROW    = 1024,
    parameter int BITVROW    = 10,
    parameter int BITPADR    = 14,
    parameter int BITPBNK    = 4,
    parameter int SRAM_DELAY = 2,
    parameter int ERRCNTW    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_1r1w_resp_if.slave       bus,
    output logic [ERRCNTW-1:0]    err_cnt
);
    localparam int PADRW = BITPADR - BITPBNK;
    localparam logic [BITVROW:0] ROWS = NUMVROW[BITVROW:0];

    typedef struct packed {
        logic              vld;
        logic [WIDTH-1:0]  data;
        logic              fwd;
        logic              serr;
        logic              derr;
        logic [PADRW-1:0]  padr;
    } stage_t;

    logic [WIDTH-1:0] mem [NUMVROW];
    logic             a_ok;
    logic             b_ok;
    stage_t           cap;
    stage_t           last;

    // Storage write; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (bus.writeA && a_ok) begin
            mem[bus.addrA] <= bus.dinA;
        end
    end

    // Build the stage-1 entry: range checks, write-through, injected flips.
    always_comb begin
        a_ok     = {1'b0, bus.addrA} < ROWS;
        b_ok     = {1'b0, bus.addrB} < ROWS;
        cap      = '0;
        cap.vld  = bus.readB;
        cap.padr = PADRW'(bus.addrB);
        if (bus.readB && b_ok) begin
            cap.fwd     = bus.writeA && a_ok && (bus.addrA == bus.addrB);
            cap.derr    = bus.inj_derr;
            cap.serr    = bus.inj_serr && !bus.inj_derr;
            cap.data    = cap.fwd ? bus.dinA : mem[bus.addrB];
            cap.data[0] = cap.data[0] ^ (cap.serr | cap.derr);
            cap.data[1] = cap.data[1] ^ cap.derr;
        end
    end

    // The output registers are the final stage, so only SRAM_DELAY-1
    // intermediate stages exist; latency 1 feeds the outputs directly.
    if (SRAM_DELAY > 1) begin : g_pipe
        stage_t pipe [SRAM_DELAY-1];

        // Shift request entries toward the output; reset drops all in flight.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int unsigned i = 0; i < SRAM_DELAY - 1; i++) begin
                    pipe[i] <= '0;
                end
            end else begin
                pipe[0] <= cap;
                for (int unsigned i = 1; i < SRAM_DELAY - 1; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
        end

        assign last = pipe[SRAM_DELAY-2];
    end else begin : g_nopipe
        assign last = cap;
    end

    // Present the response; data and address hold while idle, flags drop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.vldB  <= 1'b0;
            bus.doutB <= '0;
            bus.fwrdB <= 1'b0;
            bus.serrB <= 1'b0;
            bus.derrB <= 1'b0;
            bus.padrB <= '0;
        end else begin
            bus.vldB  <= last.vld;
            bus.fwrdB <= last.vld & last.fwd;
            bus.serrB <= last.vld & last.serr;
            bus.derrB <= last.vld & last.derr;
            if (last.vld) begin
                bus.doutB <= last.data;
                bus.padrB <= last.padr;
            end
        end
    end

    // Saturating count of responses that carry an error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= '0;
        end else if (last.vld && (last.serr || last.derr) && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
endmodule

// File: doc/sram_1r1w_resp.md
Name: sram_1r1w_resp

Overview:
Cycle-accurate responder model for one physical 1R1W memory bank: the memory-side end of the t*_writeA/addrA/dinA/readB/addrB/doutB/fwrdB/serrB/derrB/padrB interface that nr2w algorithm cores drive.
- Instantiated once per bank by the formal and simulation harnesses (t1 data banks, t2 spare, t3 map).
- Provides a programmable read latency, write-through forwarding, error injection and physical-address return, so core behaviour can be checked against a real memory timing.

Parameters:
WIDTH, 32, data word width in bits (>= 2).
NUMVROW, 1024, number of rows.
BITVROW, 10, row address width.
BITPADR, 14, full physical address width.
BITPBNK, 4, bank-select bits; padrB width is BITPADR-BITPBNK (must be >= BITVROW).
SRAM_DELAY, 2, read latency in cycles (>= 1).
ERRCNTW, 8, width of the saturating error counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, asynchronous assert, active-low (0 = in reset); synchronous release.
writeA  in  1  write enable.
addrA  in  BITVROW  write row address.
dinA  in  WIDTH  write data.
readB  in  1  read enable.
addrB  in  BITVROW  read row address.
inj_serr  in  1  flip bit 0 of this read's data and flag a single-bit error; sampled with readB.
inj_derr  in  1  flip bits 0 and 1 of this read's data and flag a double-bit error; sampled with readB.
vldB  out  1  read response valid.
doutB  out  WIDTH  read data.
fwrdB  out  1  response came from a same-cycle write.
serrB  out  1  single-bit error flag.
derrB  out  1  double-bit error flag.
padrB  out  BITPADR-BITPBNK  zero-extended addrB of the read.
err_cnt  out  ERRCNTW  count of responses with serrB or derrB set; saturates at all-ones.

Behaviour:
Storage
- Storage is a NUMVROW x WIDTH flop array. It is not cleared by reset and keeps its contents across reset.
- Write: writeA=1 with addrA<NUMVROW updates the row at the clock edge. A write with addrA>=NUMVROW is ignored.

Read request (cycle N)
- readB=1 captures into pipeline stage 1: addrB, the array data, the forward flag and the injection flags.
- Same-cycle write-through: if writeA=1 and addrA==addrB (both in range), the captured data is dinA and fwd=1. Otherwise data is the array row and fwd=0.
- Out-of-range read (addrB>=NUMVROW): captured data is 0, fwd=0, serrB=derrB=0, injection flags are ignored; padrB still reports addrB.

Response timing
- The response appears on the outputs in cycle N+SRAM_DELAY, with vldB=1 for exactly one cycle.
- The pipeline is a SRAM_DELAY-deep shift register of {vld, data, fwd, serr, derr, padr}.
- A new read is accepted every cycle with no stall; responses emerge in issue order.

Output values
- When vldB=0, doutB holds its last value, and fwrdB, serrB and derrB are 0.
- Injection: if inj_derr=1 (derr takes priority over serr), doutB = data XOR 3 with derrB=1 and serrB=0. Else if inj_serr=1, doutB = data XOR 1 with serrB=1.
- Injection applies to forwarded data as well.
- err_cnt increments by 1 on each vldB cycle with serrB|derrB. It holds at 2^ERRCNTW-1.
- readB=0 ignores addrB and the injection inputs.

Reset (rst=0)
- All pipeline stages are invalidated immediately.
- Outputs go to: vldB=0, doutB=0, fwrdB=0, serrB=0, derrB=0, padrB=0, err_cnt=0.
- Any read in flight when reset asserts is dropped and never produces a response.
- The first read after release is accepted in the first cycle with rst=1.

Test Plan:
- Write 0xDEADBEEF to row 5 (cycle 0); readB row 5 in cycle 1 -> cycle 3 (SRAM_DELAY=2): vldB=1, doutB=0xDEADBEEF, fwrdB=0, padrB=5, serrB=derrB=0.
- Same cycle: writeA row 7 with 0x12345678 and readB row 7 -> two cycles later doutB=0x12345678, fwrdB=1; a second read of row 7 gives the same data with fwrdB=0.
- Rows 0..3 hold 0xA0..0xA3; read rows 0,1,2,3 back-to-back -> vldB high four consecutive cycles with doutB 0xA0,0xA1,0xA2,0xA3 in order.
- Row 9 holds 0xF0: read with inj_serr=1 -> doutB=0xF1, serrB=1; then read with inj_serr=1 and inj_derr=1 -> doutB=0xF3, derrB=1, serrB=0; err_cnt=2. With ERRCNTW=2, five injected reads -> err_cnt stays at 3.
- NUMVROW=1000: write row 1010 with 0x55, then read row 1010 -> doutB=0, padrB=1010; the array is unchanged (rows 0..999 read back their prior values).
- Issue a read, assert rst=0 one cycle later -> no vldB pulse ever appears for it, all outputs are 0 during reset; after release, reading row 5 still returns 0xDEADBEEF.
